// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb control sequencer with an ack watchdog
module multicycle_ctrl #(
  parameter int unsigned WDT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] inst,
  output logic        ir_we,
  output logic [2:0]  immgen_op,
  input  logic        br_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        err
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [2:0] IMM0 = 3'd0, I_IMM = 3'd1, S_IMM = 3'd2, B_IMM = 3'd3, U_IMM = 3'd4, UJ_IMM = 3'd5;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_OP = 7'b0110011, OP_OP32 = 7'b0111011;
  state_t state_q, state_d;
  logic [6:0] opc_q, opc_d;
  logic [2:0] imm_q, imm_d, dec_imm;
  logic [7:0] wdt_q, wdt_d;
  logic legal, wdt_exp, is_ld, is_st, is_br, unused;
  assign unused = ^inst[31:7];
  assign is_ld = opc_q == OP_LOAD;
  assign is_st = opc_q == OP_STORE;
  assign is_br = opc_q == OP_BRANCH;
  assign wdt_exp = wdt_q == 8'(WDT_CYCLES - 1);
  assign immgen_op = imm_q;
  assign err = state_q == TRAP;
  always_comb begin
    legal = 1'b1;
    dec_imm = IMM0;
    case (opc_q)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: dec_imm = I_IMM;
      OP_STORE: dec_imm = S_IMM;
      OP_BRANCH: dec_imm = B_IMM;
      OP_LUI, OP_AUIPC: dec_imm = U_IMM;
      OP_JAL: dec_imm = UJ_IMM;
      OP_OP, OP_OP32: dec_imm = IMM0;
      default: legal = 1'b0;
    endcase
  end
  // watchdog defaults to zero so any entry into FETCH or MEM starts a fresh count
  always_comb begin
    state_d = state_q;
    opc_d = opc_q;
    imm_d = imm_q;
    wdt_d = '0;
    imem_req = 1'b0;
    ir_we = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    reg_we = 1'b0;
    pc_we = 1'b0;
    pc_sel = 2'd0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we = 1'b1;
          opc_d = inst[6:0];
          state_d = DECODE;
        end else if (wdt_exp) state_d = TRAP;
        else wdt_d = wdt_q + 8'd1;
      end
      DECODE: begin
        imm_d = dec_imm;
        state_d = legal ? EXEC : TRAP;
      end
      EXEC: begin
        pc_we = is_br;
        pc_sel = (is_br && br_taken) ? 2'd1 : 2'd0;
        state_d = is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = is_st;
        if (dmem_ack) begin
          pc_we = is_st;
          state_d = is_st ? FETCH : WB;
        end else if (wdt_exp) state_d = TRAP;
        else wdt_d = wdt_q + 8'd1;
      end
      WB: begin
        reg_we = 1'b1;
        pc_we = 1'b1;
        pc_sel = (opc_q == OP_JAL) ? 2'd1 : (opc_q == OP_JALR) ? 2'd2 : 2'd0;
        state_d = FETCH;
      end
      default: ;
    endcase
    if (rst) {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel} = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      opc_q <= '0;
      imm_q <= IMM0;
      wdt_q <= '0;
    end else begin
      state_q <= state_d;
      opc_q <= opc_d;
      imm_q <= imm_d;
      wdt_q <= wdt_d;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction vectors with a queued-expectation scoreboard and output monitor
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1, imem_ack = 1'b0, br_taken = 1'b0, dmem_ack = 1'b0;
  logic [31:0] inst = '0;
  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, err;
  logic [2:0] immgen_op;
  logic [1:0] pc_sel;
  int cyc = 0, vectors = 0, miscompares = 0;
  logic err_prev = 1'b0;
  logic [2:0] exp_imm = 3'd0;
  typedef struct {int cyc; logic [11:0] b;} exp_t;
  typedef struct {logic [31:0] inst; int iw, dw; logic br, noise, ill; logic [2:0] imm; int lat, mem; logic rw; logic [1:0] ps;} vec_t;
  exp_t sbq[$];
  exp_t mon_e;

  multicycle_ctrl #(.WDT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .inst(inst),
    .ir_we(ir_we), .immgen_op(immgen_op), .br_taken(br_taken), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .reg_we(reg_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] bun(logic imreq, logic ir, logic [2:0] imm, logic dreq, logic dwe,
                                      logic rwe, logic pwe, logic [1:0] ps, logic e);
    return {imreq, ir, imm, dreq, dwe, rwe, pwe, ps, e};
  endfunction

  function automatic logic [11:0] got_bun();
    return bun(imem_req, ir_we, immgen_op, dmem_req, dmem_we, reg_we, pc_we, pc_sel, err);
  endfunction

  function automatic vec_t v(logic [31:0] i, int iw, int dw, logic br, logic noise, logic ill,
                             logic [2:0] imm, int lat, int mem, logic rw, logic [1:0] ps);
    vec_t t;
    t.inst = i; t.iw = iw; t.dw = dw; t.br = br; t.noise = noise; t.ill = ill;
    t.imm = imm; t.lat = lat; t.mem = mem; t.rw = rw; t.ps = ps;
    return t;
  endfunction

  task automatic push(input int c, input logic [11:0] b);
    exp_t e;
    e.cyc = c;
    e.b = b;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // expectations for one instruction are queued up front, then its input cycles are driven
  task automatic run(input vec_t t);
    int s, m, fin;
    s = cyc;
    m = s + t.iw + 3;
    fin = t.ill ? s + t.iw + 2 : s + t.iw + t.lat - 1 + ((t.mem != 0) ? t.dw : 0);
    push(s + t.iw, bun(1'b1, 1'b1, exp_imm, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    if (t.ill) push(fin, bun(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    for (int k = 0; t.mem != 0 && k <= t.dw; k++)
      push(m + k, bun(1'b0, 1'b0, t.imm, 1'b1, t.mem == 2, 1'b0, t.mem == 2 && k == t.dw, 2'd0, 1'b0));
    if (!t.ill && t.mem != 2) push(fin, bun(1'b0, 1'b0, t.imm, 1'b0, 1'b0, t.rw, 1'b1, t.ps, 1'b0));
    exp_imm = t.imm;
    for (int c = s; c <= fin; c++) begin
      inst = t.inst;
      br_taken = t.br;
      imem_ack = (c == s + t.iw) || (t.noise && c > s + t.iw);
      dmem_ack = (t.mem != 0 && c == m + t.dw) || (t.noise && (c < m || c > m + t.dw));
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (ir_we || reg_we || pc_we || dmem_req || (err && !err_prev))) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: cyc %0d bundle %h, none queued", cyc, got_bun());
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.cyc != cyc || mon_e.b !== got_bun()) begin
          miscompares++;
          $display("FAIL event: got cyc %0d bundle %h want cyc %0d bundle %h", cyc, got_bun(), mon_e.cyc, mon_e.b);
        end
      end
    end
    err_prev <= err;
  end

  initial begin
    int s;
    tick();
    tick();
    chk("reset_outs", got_bun(), 12'h0);
    rst = 1'b0;
    #1;
    chk("first_release", got_bun(), bun(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    run(v(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0, 3'd1, 4, 0, 1'b1, 2'd0));
    run(v(32'h0000B103, 1, 3, 1'b0, 1'b0, 1'b0, 3'd1, 5, 1, 1'b1, 2'd0));
    run(v(32'h00208463, 0, 0, 1'b1, 1'b1, 1'b0, 3'd3, 3, 0, 1'b0, 2'd1));
    run(v(32'h00208463, 0, 0, 1'b0, 1'b0, 1'b0, 3'd3, 3, 0, 1'b0, 2'd0));
    run(v(32'h008000EF, 2, 0, 1'b0, 1'b0, 1'b0, 3'd5, 4, 0, 1'b1, 2'd1));
    run(v(32'h000080E7, 0, 0, 1'b0, 1'b0, 1'b0, 3'd1, 4, 0, 1'b1, 2'd2));
    run(v(32'h00112023, 0, 2, 1'b0, 1'b1, 1'b0, 3'd2, 4, 2, 1'b0, 2'd0));
    run(v(32'h123450B7, 0, 0, 1'b0, 1'b1, 1'b0, 3'd4, 4, 0, 1'b1, 2'd0));
    run(v(32'h00001117, 1, 0, 1'b0, 1'b0, 1'b0, 3'd4, 4, 0, 1'b1, 2'd0));
    run(v(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 4, 0, 1'b1, 2'd0));
    run(v(32'h0010809B, 0, 0, 1'b0, 1'b0, 1'b0, 3'd1, 4, 0, 1'b1, 2'd0));
    run(v(32'h002080BB, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 4, 0, 1'b1, 2'd0));
    run(v(32'h0000007F, 0, 0, 1'b0, 1'b0, 1'b1, 3'd0, 3, 0, 1'b0, 2'd0));
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (6) tick();
    chk("trap_hold", got_bun(), bun(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    rst = 1'b1;
    #1;
    chk("rst_clears_trap", got_bun(), 12'h0);
    tick();
    rst = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    exp_imm = 3'd0;
    #1;
    chk("trap_release", got_bun(), bun(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_midwait", got_bun(), 12'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("midwait_release", got_bun(), bun(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    run(v(32'h00500093, 3, 0, 1'b0, 1'b0, 1'b0, 3'd1, 4, 0, 1'b1, 2'd0));
    s = cyc;
    push(s + 4, bun(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    imem_ack = 1'b0;
    repeat (7) tick();
    chk("wdt_trap", got_bun(), bun(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    chk("queue_drain", 12'(sbq.size()), 12'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the core datapath. It fetches an instruction over a request/acknowledge instruction-memory port and latches the opcode. It then drives the immediate-generator selector `immgen_op`, steps the instruction through decode, execute, memory and write-back states, and issues all register, PC and data-memory strobes. It sits between the instruction/data memory interfaces and the datapath.

## Interface
- `WDT_CYCLES`, default 255: maximum wait cycles for an ack in FETCH or MEM before trapping. Legal range is 1..255.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch complete; `inst` is valid in the same cycle.
- `inst`  in  32  fetched instruction word.
- `ir_we`  out  1  instruction-register load strobe.
- `immgen_op`  out  3 (`CorePack::imm_op_enum`)  immediate format select: IMM0=0, I_IMM=1, S_IMM=2, B_IMM=3, U_IMM=4, UJ_IMM=5.
- `br_taken`  in  1  branch compare result, sampled in EXEC.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `dmem_ack`  in  1  data access complete.
- `reg_we`  out  1  register file write enable.
- `pc_we`  out  1  PC update strobe.
- `pc_sel`  out  2  next-PC source: 0 = pc+4, 1 = pc+imm, 2 = ALU result (JALR).
- `err`  out  1  sticky trap flag.

## Operation
- State register values: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- Opcode to immediate format and path (by `inst[6:0]`):
  - LOAD 0000011: I_IMM; EXEC, MEM, WB.
  - OP-IMM 0010011 and OP-IMM-32 0011011: I_IMM; EXEC, WB.
  - JALR 1100111: I_IMM; EXEC, WB.
  - STORE 0100011: S_IMM; EXEC, MEM.
  - BRANCH 1100011: B_IMM; EXEC.
  - LUI 0110111 and AUIPC 0010111: U_IMM; EXEC, WB.
  - JAL 1101111: UJ_IMM; EXEC, WB.
  - OP 0110011 and OP-32 0111011: IMM0; EXEC, WB.
  - Any other opcode: go to TRAP from DECODE.
- FETCH
  - `imem_req`=1.
  - On `imem_ack`: `ir_we`=1 in the same cycle, latch `inst[6:0]` into the internal opcode register, go to DECODE.
- DECODE
  - Load `immgen_op` (registered) from the latched opcode.
  - Go to EXEC, or to TRAP if the opcode is illegal.
- EXEC
  - BRANCH: `pc_we`=1, `pc_sel`=`br_taken`?1:0, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM
  - `dmem_req`=1; `dmem_we`=1 for STORE only.
  - On `dmem_ack`, LOAD: go to WB.
  - On `dmem_ack`, STORE: `pc_we`=1, `pc_sel`=0, go to FETCH.
- WB
  - `reg_we`=1, `pc_we`=1.
  - `pc_sel`: JAL=1, JALR=2, else 0.
  - Go to FETCH.
- Watchdog
  - 8-bit counter; cleared on entry to FETCH or MEM; increments each cycle spent waiting.
  - Reaching `WDT_CYCLES` without an ack: go to TRAP.
- TRAP
  - `err`=1. All strobes and requests are 0.
  - Held until `rst`.

## Timing
- Reset (async): state=FETCH, `immgen_op`=IMM0, opcode register=0, watchdog=0, `err`=0.
- All outputs are 0 while `rst`=1. `imem_req` rises in the first cycle after release.
- `immgen_op` is registered: valid from EXEC entry until it is reloaded in the next DECODE. It is never changed in FETCH.
- Strobes (`ir_we`, `reg_we`, `pc_we`, `dmem_*`, `imem_req`) are combinational from state and inputs. `pc_we`, `reg_we` and `ir_we` are each one cycle wide per instruction.
- Latency, counted from the cycle in which FETCH is entered, with a same-cycle ack:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each wait cycle before an ack adds one cycle.
- Ack received outside the waiting state: ignored.
- Ack arriving in the same cycle as the watchdog expiring: the ack wins.
- Reset asserted mid-access: requests drop asynchronously. After release, the sequence restarts at FETCH; the outstanding memory access is abandoned.

## Test plan
- Reset release, then `inst`=0x00500093 (addi) with immediate ack: `immgen_op`=1 from cycle 2; `reg_we` and `pc_we` high in cycle 3 with `pc_sel`=0; `imem_req` high again in cycle 4.
- Load 0x0000B103, `dmem_ack` delayed 3 cycles: `dmem_req` high for 4 cycles with `dmem_we`=0; `reg_we` asserted once, one cycle after the ack.
- Branch 0x00208463 with `br_taken`=1, then again with 0: `immgen_op`=3; `pc_we` in EXEC with `pc_sel`=1, then 0; `reg_we` never asserts.
- JAL 0x008000EF, then JALR 0x000080E7: `immgen_op`=5, then 1; WB `pc_sel`=1, then 2.
- Illegal opcode 0x0000007F: TRAP entered after DECODE, `err`=1 and stays high; no further `imem_req` until `rst`.
- Hold `imem_ack` low with `WDT_CYCLES`=4: TRAP after 4 wait cycles. Repeat with `rst` pulsed mid-wait: `imem_req` drops immediately and reasserts after release, `err`=0.
